// File: rtl/sobel_grad_sq_stream.sv
// sobel_grad_sq_stream
// Streaming 3x3 Sobel gradient stage. Accepts an 8-bit raster-order pixel stream, keeps two
// previous rows in line buffers, and for every fully interior pixel emits the scaled and
// saturated squared gradient magnitude (Gx^2 + Gy^2) >> SHIFT as a 16-bit radicand.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   pixel qualifier
//   in_sof     start of frame (only meaningful with in_valid)
//   in_pixel   8-bit unsigned pixel
//   out_valid  out_R / out_eol valid this cycle
//   out_R      scaled, saturated Gx^2+Gy^2
//   out_eol    marks the last valid output of each row
module sobel_grad_sq_stream #(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned SHIFT = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        in_sof,
   input  logic [7:0]  in_pixel,
   output logic        out_valid,
   output logic [15:0] out_R,
   output logic        out_eol
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   // ---------------------------------------------------------------- counters
   logic [CW-1:0] col_q, col_d, col_eff;
   logic [RW-1:0] row_q, row_d, row_eff;

   always_comb begin
      // A start-of-frame pixel is placed at (0,0) regardless of the running position.
      col_eff = in_sof ? '0 : col_q;
      row_eff = in_sof ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (in_valid) begin
         if (col_eff == COL_LAST) begin
            col_d = '0;
            row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
         end else begin
            col_d = col_eff + CW'(1);
            row_d = row_eff;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // ------------------------------------------------------------ line buffers
   // lb0 holds row r-2, lb1 holds row r-1. Contents are deliberately not reset: the window
   // valid bit keeps stale data from ever reaching the output.
   logic [7:0] lb0 [IMG_W];
   logic [7:0] lb1 [IMG_W];
   logic [7:0] lb0_rd, lb1_rd;

   assign lb0_rd = lb0[col_eff];
   assign lb1_rd = lb1[col_eff];

   always_ff @(posedge clk) begin
      if (in_valid) begin
         lb0[col_eff] <= lb1_rd;
         lb1[col_eff] <= in_pixel;
      end
   end

   // ------------------------------------------------------------------ window
   // win[r][c]: r=0 oldest row, c=0 oldest column.
   logic [7:0] win [3][3];
   logic       win_v, win_eol;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
         win_v   <= 1'b0;
         win_eol <= 1'b0;
      end else begin
         // col>=2 keeps the window from straddling two rows.
         win_v   <= in_valid && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
         win_eol <= in_valid && (col_eff == COL_LAST);
         if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= in_pixel;
         end
      end
   end

   // ------------------------------------------------------- stage 1: Gx, Gy
   logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
   logic signed [10:0] gx_d, gy_d;
   logic signed [10:0] gx_q, gy_q;
   logic               v1, eol1;

   always_comb begin
      gx_pos = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b0, win[2][2]};
      gx_neg = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b0, win[2][0]};
      gy_pos = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b0, win[2][2]};
      gy_neg = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b0, win[0][2]};
      gx_d   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
      gy_d   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gx_q <= '0;
         gy_q <= '0;
         v1   <= 1'b0;
         eol1 <= 1'b0;
      end else begin
         gx_q <= gx_d;
         gy_q <= gy_d;
         v1   <= win_v;
         eol1 <= win_eol;
      end
   end

   // ------------------------------------------------ stage 2: Gx^2, Gy^2
   // Squaring the magnitude avoids a signed multiplier; |G| <= 1020 fits in 10 bits.
   function automatic logic [9:0] mag(input logic signed [10:0] v);
      mag = v[10] ? 10'(-v) : v[9:0];
   endfunction

   logic [9:0]  gx_m, gy_m;
   logic [19:0] gx_sq_q, gy_sq_q;
   logic        v2, eol2;

   assign gx_m = mag(gx_q);
   assign gy_m = mag(gy_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gx_sq_q <= '0;
         gy_sq_q <= '0;
         v2      <= 1'b0;
         eol2    <= 1'b0;
      end else begin
         gx_sq_q <= 20'(gx_m) * 20'(gx_m);
         gy_sq_q <= 20'(gy_m) * 20'(gy_m);
         v2      <= v1;
         eol2    <= eol1;
      end
   end

   // ----------------------------------------- stage 3: sum, shift, saturate
   logic [20:0] s_sum, t_shift;
   logic [15:0] r_sat;

   always_comb begin
      s_sum   = {1'b0, gx_sq_q} + {1'b0, gy_sq_q};
      t_shift = s_sum >> SHIFT;
      r_sat   = (|t_shift[20:16]) ? 16'hFFFF : t_shift[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_R     <= '0;
         out_eol   <= 1'b0;
      end else begin
         out_valid <= v2;
         out_R     <= v2 ? r_sat : '0;
         out_eol   <= v2 && eol2;
      end
   end

endmodule
